// File: rtl/seg7_pattern_decoder.sv
// 7-segment bus receiver: sync, settle, decode to digit/glyph, valid/ready out.
// Optional SEG7_DEC_STATS_EN adds saturating digit/invalid counters.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic             out_valid,
    output logic [3:0]       out_digit,
    output logic [1:0]       out_kind,
`ifdef SEG7_DEC_STATS_EN
    output logic             overrun,
    output logic [CNT_W-1:0] digit_count,
    output logic [CNT_W-1:0] invalid_count
`else
    output logic             overrun
`endif
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STB = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] ONE = SW'(1);
    localparam logic [6:0] BLANK = 7'b0000000;

    logic [6:0]    r_s1;
    logic [6:0]    r_s2;
    logic [6:0]    r_cand;
    logic [SW-1:0] r_cnt;
    logic          r_evt;
    logic [6:0]    r_evt_pat;
    logic [6:0]    r_last;
    logic          r_valid;
    logic [3:0]    r_digit;
    logic [1:0]    r_kind;
    logic          r_ovr;

    logic          w_same;
    logic [SW-1:0] w_cnt_nxt;
    logic          w_hit;
    logic          w_new;
    logic          w_free;
    logic          w_load;
    logic          w_drop;
    logic [5:0]    w_dec;

    function automatic logic [5:0] f_decode(input logic [6:0] p);
        logic [5:0] v;
        case (p)
            7'b1111110: v = {2'b00, 4'd0};
            7'b0110000: v = {2'b00, 4'd1};
            7'b1101101: v = {2'b00, 4'd2};
            7'b1111001: v = {2'b00, 4'd3};
            7'b0110011: v = {2'b00, 4'd4};
            7'b1011011: v = {2'b00, 4'd5};
            7'b1011111: v = {2'b00, 4'd6};
            7'b1110000: v = {2'b00, 4'd7};
            7'b1111111: v = {2'b00, 4'd8};
            7'b1111011: v = {2'b00, 4'd9};
            7'b0011101: v = {2'b01, 4'd0};
            default:    v = {2'b10, 4'd0};
        endcase
        return v;
    endfunction

    // Count saturates at STB; the hit fires only on the sample that reaches it.
    always_comb begin
        w_same    = (r_s2 == r_cand);
        w_cnt_nxt = ONE;
        if (w_same) begin
            w_cnt_nxt = (r_cnt == STB) ? STB : r_cnt + ONE;
        end
        w_hit  = (w_cnt_nxt == STB) && (!w_same || (r_cnt != STB));
        w_dec  = f_decode(r_evt_pat);
        w_new  = r_evt && (r_evt_pat != r_last) && (r_evt_pat != BLANK);
        w_free = !r_valid || out_ready;
        w_load = w_new && w_free;
        w_drop = w_new && !w_free;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= BLANK;
            r_s2 <= BLANK;
        end else begin
            r_s1 <= seg_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand    <= BLANK;
            r_cnt     <= '0;
            r_evt     <= 1'b0;
            r_evt_pat <= BLANK;
        end else begin
            if (!w_same) begin
                r_cand <= r_s2;
            end
            r_cnt     <= w_cnt_nxt;
            r_evt     <= w_hit;
            r_evt_pat <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= BLANK;
            r_valid <= 1'b0;
            r_digit <= 4'd0;
            r_kind  <= 2'b00;
            r_ovr   <= 1'b0;
        end else begin
            if (r_evt && (r_evt_pat != r_last)) begin
                r_last <= r_evt_pat;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_kind  <= w_dec[5:4];
                r_digit <= w_dec[3:0];
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (clr_overrun) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_digit = r_digit;
    assign out_kind  = r_kind;
    assign overrun   = r_ovr;

`ifdef SEG7_DEC_STATS_EN
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_icnt;
    logic             w_inc_d;
    logic             w_inc_i;

    always_comb begin
        w_inc_d = w_load && (w_dec[5:4] == 2'b00);
        w_inc_i = w_new && (w_dec[5:4] == 2'b10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= '0;
            r_icnt <= '0;
        end else begin
            if (w_inc_d && (r_dcnt != '1)) begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            if (w_inc_i && (r_icnt != '1)) begin
                r_icnt <= r_icnt + 1'b1;
            end
        end
    end

    assign digit_count   = r_dcnt;
    assign invalid_count = r_icnt;
`endif

endmodule
